// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_pkg
//  Description : Shared definitions for the multicycle controller: FSM state
//                codes, instruction opcodes and ALUOp encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    // State codes double as the 4-bit debug State output, so the values are
    // fixed. Codes 12..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_BNE  = 6'b000101;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_ORI  = 6'b001101;

    // ALUOp encodings; RTYPE defers to the funct field in the ALU control.
    localparam logic [2:0] c_ALUOP_NONE  = 3'b000;
    localparam logic [2:0] c_ALUOP_SUB   = 3'b001;
    localparam logic [2:0] c_ALUOP_ADD   = 3'b100;
    localparam logic [2:0] c_ALUOP_OR    = 3'b101;
    localparam logic [2:0] c_ALUOP_RTYPE = 3'b111;

endpackage
`default_nettype wire

// File: rtl/mc_opcode_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_opcode_decode
//  Description : Combinational map from instruction opcode to the state that
//                follows DECODE, plus an illegal-opcode flag.
//  Ports       : opcode     - IR[31:26]
//                next_state - successor of DECODE
//                illegal    - opcode is not supported (next_state = FETCH)
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_opcode_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    output state_t     next_state,
    output logic       illegal
);

    always_comb begin
        next_state = S_FETCH;
        illegal    = 1'b0;
        case (opcode)
            c_OP_R:             next_state = S_R_EXEC;
            c_OP_LW, c_OP_SW:   next_state = S_MEM_ADDR;
            c_OP_BEQ, c_OP_BNE: next_state = S_BRANCH;
            c_OP_J:             next_state = S_JUMP;
            c_OP_ADDI, c_OP_ORI: next_state = S_I_EXEC;
            default:            illegal    = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore-style control FSM for a multicycle MIPS-like datapath.
//  Ports       : clk, reset (async, active low)
//                Opcode   - IR[31:26], sampled in DECODE
//                Zero     - ALU zero flag, used in BRANCH
//                MemReady - memory handshake, access completes when 1
//                PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
//                RegWrite, ALUSrcA, ALUSrcB[1:0], PCSource[1:0], ALUOp[2:0]
//                           - datapath controls
//                State[3:0] - current state (debug)
//                IllegalOp  - pulses in DECODE for an unsupported opcode
//  Parameters  : MEM_WAIT_EN - 1: memory states wait for MemReady,
//                              0: MemReady is treated as always 1
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic [3:0] State,
    output logic       IllegalOp
);

    state_t     r_state;
    logic [5:0] r_opcode;
    state_t     w_dec_next;
    logic       w_dec_illegal;
    logic       w_ready;

    assign w_ready = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;

    mc_opcode_decode u_decode (
        .opcode     (Opcode),
        .next_state (w_dec_next),
        .illegal    (w_dec_illegal)
    );

    // State register. The opcode is captured on the DECODE edge so that the
    // execute/memory states are immune to IR changes after decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
        end else begin
            case (r_state)
                S_FETCH:     if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_state  <= w_dec_next;
                    r_opcode <= Opcode;
                end
                S_MEM_ADDR:  r_state <= (r_opcode == c_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (w_ready) r_state <= S_MEM_WB;
                S_MEM_WRITE: if (w_ready) r_state <= S_FETCH;
                S_R_EXEC:    r_state <= S_R_WB;
                S_I_EXEC:    r_state <= S_I_WB;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    assign State = r_state;

    // Output decode from the registered state. The only input terms are the
    // strobes qualified by MemReady/Zero and the DECODE illegal flag.
    always_comb begin
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        MemtoReg  = 1'b0;
        RegDst    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSource  = 2'b00;
        ALUOp     = c_ALUOP_NONE;
        IllegalOp = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = c_ALUOP_ADD;
                IRWrite = w_ready;
                PCWrite = w_ready;
            end
            S_DECODE: begin
                ALUSrcB   = 2'b11;
                ALUOp     = c_ALUOP_ADD;
                IllegalOp = w_dec_illegal;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = c_ALUOP_ADD;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = c_ALUOP_RTYPE;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (r_opcode == c_OP_ORI) ? c_ALUOP_OR : c_ALUOP_ADD;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = c_ALUOP_SUB;
                PCSource = 2'b01;
                PCWrite  = (r_opcode == c_OP_BNE) ? ~Zero : Zero;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. A table of
//                per-cycle {inputs, expected State, expected outputs} records
//                walks through every instruction class; hand-written
//                sequences cover reset behaviour, including reset in a wait
//                state. Expected values go through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;
    logic       IllegalOp;

    multicycle_control #(.MEM_WAIT_EN(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .Opcode    (Opcode),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .MemtoReg  (MemtoReg),
        .RegDst    (RegDst),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .PCSource  (PCSource),
        .ALUOp     (ALUOp),
        .State     (State),
        .IllegalOp (IllegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order:
    // {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
    //  ALUSrcB[1:0],PCSource[1:0],ALUOp[2:0],IllegalOp}
    logic [16:0] outs;
    assign outs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp};

    localparam logic [16:0] O_F   = {9'b101010000, 2'b01, 2'b00, 3'b100, 1'b0};
    localparam logic [16:0] O_FW  = {9'b001000000, 2'b01, 2'b00, 3'b100, 1'b0};
    localparam logic [16:0] O_D   = {9'b000000000, 2'b11, 2'b00, 3'b100, 1'b0};
    localparam logic [16:0] O_DI  = {9'b000000000, 2'b11, 2'b00, 3'b100, 1'b1};
    localparam logic [16:0] O_MA  = {9'b000000001, 2'b10, 2'b00, 3'b100, 1'b0};
    localparam logic [16:0] O_MR  = {9'b011000000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] O_MWB = {9'b000001010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] O_MW  = {9'b010100000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] O_RX  = {9'b000000001, 2'b00, 2'b00, 3'b111, 1'b0};
    localparam logic [16:0] O_RWB = {9'b000000110, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] O_IA  = {9'b000000001, 2'b10, 2'b00, 3'b100, 1'b0};
    localparam logic [16:0] O_IO  = {9'b000000001, 2'b10, 2'b00, 3'b101, 1'b0};
    localparam logic [16:0] O_IWB = {9'b000000010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] O_BT  = {9'b100000001, 2'b00, 2'b01, 3'b001, 1'b0};
    localparam logic [16:0] O_BN  = {9'b000000001, 2'b00, 2'b01, 3'b001, 1'b0};
    localparam logic [16:0] O_J   = {9'b100000000, 2'b00, 2'b10, 3'b000, 1'b0};

    localparam logic [5:0] X = 6'b111111;  // opcode noise outside DECODE

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] o;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] o;
        int          id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_step  = 0;

    task automatic add(input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic [16:0] o);
        vec_t v;
        v.op = op; v.z = z; v.mr = mr; v.st = st; v.o = o;
        vecs.push_back(v);
    endtask

    task automatic expect_now(input logic [3:0] st, input logic [16:0] o);
        exp_t e;
        e.st = st; e.o = o; e.id = n_step;
        sb.push_back(e);
        n_step++;
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        if (State !== e.st) begin
            n_fail++;
            $display("FAIL step%0d state: got %0d want %0d", e.id, State, e.st);
        end
        n_tests++;
        if (outs !== e.o) begin
            n_fail++;
            $display("FAIL step%0d outputs: got %b want %b", e.id, outs, e.o);
        end
    endtask

    // Called at posedge+1: drive, check at the following negedge, and return
    // at posedge+1 of the next cycle.
    task automatic step(input logic [5:0] op, input logic z, input logic mr,
                        input logic [3:0] st, input logic [16:0] o);
        Opcode = op; Zero = z; MemReady = mr;
        expect_now(st, o);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // R-type
        add(X,         0, 1, 4'd0,  O_F);
        add(6'b000000, 0, 1, 4'd1,  O_D);
        add(X,         0, 1, 4'd6,  O_RX);
        add(X,         0, 1, 4'd7,  O_RWB);
        // lw, two wait cycles; opcode input changed to sw after decode
        add(X,         0, 1, 4'd0,  O_F);
        add(6'b100011, 0, 1, 4'd1,  O_D);
        add(6'b101011, 0, 1, 4'd2,  O_MA);
        add(X,         0, 0, 4'd3,  O_MR);
        add(X,         0, 0, 4'd3,  O_MR);
        add(X,         0, 1, 4'd3,  O_MR);
        add(X,         0, 1, 4'd4,  O_MWB);
        // sw with one fetch wait and one write wait
        add(X,         0, 0, 4'd0,  O_FW);
        add(X,         0, 1, 4'd0,  O_F);
        add(6'b101011, 0, 1, 4'd1,  O_D);
        add(6'b100011, 0, 1, 4'd2,  O_MA);
        add(X,         0, 0, 4'd5,  O_MW);
        add(X,         0, 1, 4'd5,  O_MW);
        // beq Zero=1 (taken)
        add(X,         0, 1, 4'd0,  O_F);
        add(6'b000100, 0, 1, 4'd1,  O_D);
        add(X,         1, 1, 4'd8,  O_BT);
        // bne Zero=1 (not taken)
        add(X,         0, 1, 4'd0,  O_F);
        add(6'b000101, 0, 1, 4'd1,  O_D);
        add(X,         1, 1, 4'd8,  O_BN);
        // bne Zero=0 (taken)
        add(X,         0, 1, 4'd0,  O_F);
        add(6'b000101, 0, 1, 4'd1,  O_D);
        add(X,         0, 1, 4'd8,  O_BT);
        // j
        add(X,         0, 1, 4'd0,  O_F);
        add(6'b000010, 0, 1, 4'd1,  O_D);
        add(X,         0, 1, 4'd9,  O_J);
        // addi, opcode input flipped to ori after decode
        add(X,         0, 1, 4'd0,  O_F);
        add(6'b001000, 0, 1, 4'd1,  O_D);
        add(6'b001101, 0, 1, 4'd10, O_IA);
        add(X,         0, 1, 4'd11, O_IWB);
        // ori, opcode input flipped to addi after decode
        add(X,         0, 1, 4'd0,  O_F);
        add(6'b001101, 0, 1, 4'd1,  O_D);
        add(6'b001000, 0, 1, 4'd10, O_IO);
        add(X,         0, 1, 4'd11, O_IWB);
        // illegal opcodes: one-cycle IllegalOp pulse, straight back to FETCH
        add(X,         0, 1, 4'd0,  O_F);
        add(6'b111111, 0, 1, 4'd1,  O_DI);
        add(6'b000000, 0, 1, 4'd0,  O_F);
        add(6'b010101, 0, 1, 4'd1,  O_DI);
        add(X,         0, 0, 4'd0,  O_FW);

        // Reset state, with and without MemReady
        reset = 1'b0; Opcode = '0; Zero = 1'b0; MemReady = 1'b0;
        #12;
        expect_now(4'd0, O_FW); check_out();
        MemReady = 1'b1;
        #1;
        expect_now(4'd0, O_F);  check_out();
        @(posedge clk); #1;
        expect_now(4'd0, O_F);  check_out();
        reset = 1'b1;

        foreach (vecs[i])
            step(vecs[i].op, vecs[i].z, vecs[i].mr, vecs[i].st, vecs[i].o);

        // sw aborted by reset while MEM_WRITE waits on MemReady
        step(X,         0, 1, 4'd0, O_F);
        step(6'b101011, 0, 1, 4'd1, O_D);
        step(X,         0, 1, 4'd2, O_MA);
        step(X,         0, 0, 4'd5, O_MW);
        reset = 1'b0;              // mid-cycle, state still MEM_WRITE
        #1;
        expect_now(4'd0, O_FW); check_out();
        @(negedge clk);
        expect_now(4'd0, O_FW); check_out();
        @(posedge clk); #1;
        reset = 1'b1;
        step(X,         0, 0, 4'd0, O_FW);
        step(X,         0, 0, 4'd0, O_FW);
        step(X,         0, 1, 4'd0, O_F);
        step(6'b000000, 0, 1, 4'd1, O_D);
        step(X,         0, 1, 4'd6, O_RX);
        step(X,         0, 1, 4'd7, O_RWB);
        step(X,         0, 0, 4'd0, O_FW);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1, meaning: 1 = memory states wait for MemReady; 0 = MemReady treated as constant 1.
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Opcode  input  6  IR[31:26], sampled in DECODE only.
REQ-005 SHALL have port Zero  input  1  ALU zero flag, used in BRANCH only.
REQ-006 SHALL have port MemReady  input  1  memory handshake, access completes in the cycle it is 1.
REQ-007 SHALL have outputs PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA (1 bit each); ALUSrcB and PCSource (2 bits each); ALUOp (3 bits); State (4 bits, debug); IllegalOp (1 bit, one-cycle pulse).

Function
REQ-008 SHALL implement a Moore FSM: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-009 SHALL drive ALUOp codes: 111 R-type (funct decoded downstream), 100 add, 101 or, 001 subtract/compare.
REQ-010 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00; IRWrite and PCWrite SHALL be 1 only in the cycle MemReady=1; advance to DECODE on MemReady=1, else hold.
REQ-011 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100; next state by Opcode: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100/000101->BRANCH, 000010->JUMP, 001000/001101->I_EXEC, any other->FETCH with IllegalOp=1 for that DECODE cycle.
REQ-012 SHALL latch Opcode into an internal register on the DECODE cycle; later states SHALL use the latched value.
REQ-013 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=100; lw->MEM_READ, sw->MEM_WRITE.
REQ-014 MEM_READ: MemRead=1, IorD=1; hold until MemReady=1, then MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; ->FETCH.
REQ-015 MEM_WRITE: IorD=1; MemWrite=1 while waiting; ->FETCH in the cycle MemReady=1.
REQ-016 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111; ->R_WB. R_WB: RegWrite=1, RegDst=1, MemtoReg=0; ->FETCH.
REQ-017 I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=100 for addi, 101 for ori; ->I_WB. I_WB: RegWrite=1, RegDst=0, MemtoReg=0; ->FETCH.
REQ-018 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01; PCWrite = Zero for beq, ~Zero for bne; ->FETCH.
REQ-019 JUMP: PCSource=10, PCWrite=1; ->FETCH.
REQ-020 Every output not listed for a state SHALL be 0; PCWrite, IRWrite, RegWrite and MemWrite SHALL never assert outside the states named above.
REQ-021 CPI SHALL be: lw 5, sw 4, R/I-type 4, beq/bne 3, j 3, illegal 2, plus one cycle per MemReady=0 cycle in any wait state.

Reset
REQ-022 reset low SHALL asynchronously force State=FETCH and clear the latched opcode; all outputs SHALL then equal the FETCH values, with IRWrite=PCWrite=0 unless MemReady=1.
REQ-023 Reset asserted in any state, including a wait state, SHALL abort the instruction with no further write strobes; fetch resumes on the first clk edge after release.

Structure
REQ-024 A shared package SHALL hold the state codes, opcode constants (R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, ADDI=001000, ORI=001101) and the ALUOp codes.
REQ-025 A combinational sub-module mc_opcode_decode SHALL map Opcode to the DECODE next state and IllegalOp; the remaining logic (state register plus output decode) SHALL stay in multicycle_control.

Verification
REQ-026 Reset release, MemReady=1, Opcode=000000: States 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7.
REQ-027 lw (100011), MemReady low for 2 cycles in MEM_READ: States 0,1,2,3,3,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-028 beq, Zero=1: PCWrite=1, PCSource=01 in state 8. bne, Zero=1: PCWrite=0 in state 8.
REQ-029 Opcode=111111: IllegalOp=1 for exactly one cycle in DECODE; next State=0; no RegWrite or MemWrite.
REQ-030 sw, reset driven low while in MEM_WRITE with MemReady=0: State=0 immediately with MemWrite=0; no MemWrite after reset release until a new sw reaches state 5.
